// File: rtl/apb_slv_regfile.sv
// -----------------------------------------------------------------------------
// apb_slv_regfile
//
// Small APB-style register file for housekeeping and configuration. It holds
// NUM_REGS-2 read/write words, a saturating 16-bit error counter and a
// constant ID word. Every transfer is stretched by WAIT_CYCLES access cycles
// with P_ready low.
//
// Ports
//   Pclk      in   1   clock, rising edge
//   Prst      in   1   asynchronous reset, active low
//   Paddr     in  32   byte address, decoded live every cycle
//   PSELx     in   1   slave select
//   P_en      in   1   enable, high during the access phase
//   P_WR      in   1   1 = write, 0 = read
//   PWdata    in  32   write data
//   PRdata    out 32   read data, zero unless a clean read is completing
//   P_ready   out  1   transfer completion
//   P_slverr  out  1   error response, only while P_ready is high
//
// Register map (word index from BASE_ADDR)
//   0 .. NUM_REGS-3   RW   general purpose
//   NUM_REGS-2        RO   ERRCNT, 16-bit, zero-extended
//   NUM_REGS-1        RO   ID = 32'hA9B0_0001
//
// FSM
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no transfer in flight; a setup cycle loads wcnt and moves on
//   ST_ACCESS | access phase; P_ready = (wcnt == 0); completes on P_en edge
// -----------------------------------------------------------------------------
module apb_slv_regfile #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        Pclk,
   input  logic        Prst,
   input  logic [31:0] Paddr,
   input  logic        PSELx,
   input  logic        P_en,
   input  logic        P_WR,
   input  logic [31:0] PWdata,
   output logic [31:0] PRdata,
   output logic        P_ready,
   output logic        P_slverr
);

   localparam int                 NUM_RW     = NUM_REGS - 2;
   localparam int                 IDX_W      = $clog2(NUM_REGS);
   localparam logic [32:0]        END_ADDR   = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);
   localparam logic [IDX_W-1:0]   IDX_ERRCNT = IDX_W'(NUM_REGS - 2);
   localparam logic [IDX_W-1:0]   IDX_ID     = IDX_W'(NUM_REGS - 1);
   localparam logic [31:0]        ID_VALUE   = 32'hA9B0_0001;
   localparam logic [3:0]         WAIT_INIT  = 4'(WAIT_CYCLES);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  wcnt_q;
   logic [3:0]  wcnt_d;
   logic        complete;

   logic [31:0] regs_q [NUM_RW];
   logic [15:0] errcnt_q;

   // ---------------------------------------------------------------------------
   // Address decode (live Paddr)
   // ---------------------------------------------------------------------------
   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             below_base;
   logic             past_end;
   logic             misaligned;
   logic             addr_err;
   logic             wr_ro_err;
   logic             err;
   logic             unused_offset;

   assign offset     = Paddr - BASE_ADDR;
   assign idx        = offset[IDX_W+1:2];
   // Only the word-index bits of the offset matter once the range is checked.
   assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

   assign below_base = (Paddr < BASE_ADDR);
   assign past_end   = ({1'b0, Paddr} >= END_ADDR);
   assign misaligned = |Paddr[1:0];
   assign addr_err   = below_base | past_end | misaligned;
   // The two read-only words sit at the top of the map.
   assign wr_ro_err  = P_WR & ~addr_err & (idx >= IDX_ERRCNT);
   assign err        = addr_err | wr_ro_err;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // P_en high without a preceding setup is ignored.
            if (PSELx && !P_en) begin
               state_d = ST_ACCESS;
               wcnt_d  = WAIT_INIT;
            end
         end
         ST_ACCESS: begin
            if (!PSELx) begin
               // Master abandoned the transfer: nothing commits, nothing counts.
               state_d = ST_IDLE;
            end else if (P_en) begin
               if (wcnt_q != 4'd0) begin
                  wcnt_d = wcnt_q - 4'd1;
               end else begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign P_ready  = (state_q == ST_ACCESS) && (wcnt_q == 4'd0);
   assign P_slverr = P_ready & err;

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         for (int i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else if (complete && !err && P_WR) begin
         // err already excludes the read-only words, so idx is an RW slot here.
         for (int i = 0; i < NUM_RW; i++) begin
            if (idx == IDX_W'(i)) begin
               regs_q[i] <= PWdata;
            end
         end
      end
   end

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         errcnt_q <= 16'h0;
      end else if (complete && err && (errcnt_q != 16'hFFFF)) begin
         errcnt_q <= errcnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Read path; ERRCNT reads its registered value, i.e. the pre-increment count
   // when the same transfer is the one being counted.
   // ---------------------------------------------------------------------------
   logic [31:0] rd_data;

   always_comb begin
      rd_data = 32'h0;
      if (idx == IDX_ID) begin
         rd_data = ID_VALUE;
      end else if (idx == IDX_ERRCNT) begin
         rd_data = {16'h0, errcnt_q};
      end else begin
         for (int i = 0; i < NUM_RW; i++) begin
            if (idx == IDX_W'(i)) begin
               rd_data = regs_q[i];
            end
         end
      end
   end

   assign PRdata = (P_ready && !P_WR && !err) ? rd_data : 32'h0;

endmodule

// File: doc/apb_slv_regfile.md
APB_SLV_REGFILE -- requirements
Module: apb_slv_regfile

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_A000, byte address of register 0.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; valid range 3..64.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, P_ready-low access cycles per transfer; valid range 0..15.
REQ-004 SHALL have port Pclk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port Prst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Paddr  input  32  byte address from the master.
REQ-007 SHALL have port PSELx  input  1  slave select.
REQ-008 SHALL have port P_en  input  1  enable, high in access phase.
REQ-009 SHALL have port P_WR  input  1  1 = write, 0 = read.
REQ-010 SHALL have port PWdata  input  32  write data.
REQ-011 SHALL have port PRdata  output  32  read data.
REQ-012 SHALL have port P_ready  output  1  active-high transfer completion.
REQ-013 SHALL have port P_slverr  output  1  error response, valid only while P_ready=1.

Function
REQ-014 SHALL implement FSM IDLE/ACCESS with a 4-bit wait counter wcnt.
REQ-015 IDLE: on PSELx=1 and P_en=0 (setup), SHALL load wcnt=WAIT_CYCLES and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-016 ACCESS: SHALL drive P_ready = (wcnt==0), combinationally from the state register and wcnt only.
REQ-017 ACCESS, PSELx=1, P_en=1, wcnt!=0: SHALL decrement wcnt and stay in ACCESS.
REQ-018 ACCESS, PSELx=1, P_en=1, wcnt==0: transfer completes on this edge and SHALL go to IDLE.
REQ-019 ACCESS with PSELx=0: abort; SHALL go to IDLE with no register update and no error-count change.
REQ-020 Back-to-back transfers: a setup cycle following a completion SHALL be accepted from IDLE with no extra idle cycle.
REQ-021 Decode from live Paddr: index = (Paddr-BASE_ADDR)>>2.
REQ-022 Error conditions SHALL be: Paddr<BASE_ADDR; Paddr>=BASE_ADDR+4*NUM_REGS; Paddr[1:0]!=0; write to a read-only register.
REQ-023 Registers 0..NUM_REGS-3 SHALL be read/write, 32 bits.
REQ-024 Register NUM_REGS-2 SHALL be read-only ERRCNT: 16-bit count zero-extended to 32 bits, +1 per errored completion, saturating at 16'hFFFF.
REQ-025 Register NUM_REGS-1 SHALL be read-only ID, constant 32'hA9B0_0001.
REQ-026 Writes SHALL commit PWdata to the RW register on the completion edge only, and only when error-free.
REQ-027 PRdata SHALL be the indexed register while P_ready=1, P_WR=0 and no error; 32'h0 at all other times.
REQ-028 P_slverr SHALL be P_ready & error; 0 at all other times.
REQ-029 An errored write SHALL leave all RW registers unchanged.
REQ-030 A read of ERRCNT in the transfer that also increments it SHALL return the pre-increment value.
REQ-031 P_en=1 in IDLE (protocol violation) SHALL be ignored: stay in IDLE, P_ready=0.

Reset
REQ-032 Prst=0 SHALL asynchronously force IDLE, wcnt=0, all RW registers=0 and ERRCNT=0.
REQ-033 During reset, PRdata SHALL be 0, P_ready=0 and P_slverr=0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the transfer without committing the write.
REQ-035 After Prst deasserts, the first setup SHALL be accepted at the next rising edge.

Verification
REQ-036 Write 32'h0000_0041 to 0xA000, then read 0xA000 (WAIT_CYCLES=1) -> exactly 1 access cycle with P_ready=0 per transfer; read returns 32'h0000_0041 with P_slverr=0.
REQ-037 Master-side increment loop: read 0xA000 = 5, write 6, read again -> PRdata=6; back-to-back transfers with no idle cycles between them.
REQ-038 Read 0xA03C -> PRdata=32'hA9B0_0001; write 0xA03C -> P_slverr=1, ID unchanged, then read 0xA038 -> 32'h0000_0001.
REQ-039 Accesses to 0xA040, 0x9FFC and 0xA002 -> P_slverr=1 and PRdata=0 for each; ERRCNT increments by 3; no RW register changes.
REQ-040 WAIT_CYCLES=0 and WAIT_CYCLES=15 -> P_ready high in the first access cycle, and after 15 low cycles, respectively.
REQ-041 Prst pulsed low during the wait cycle of a write to 0xA004 -> 0xA004 reads 0; P_ready=0 throughout reset.
